// File: rtl/im_responder_pkg.sv
// Shared constants and types for the instruction-memory SRAM responder.
// Holds the FSM state encoding and the default interface geometry.
package im_responder_pkg;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int ADDR_W_DEF      = 14;
  localparam int WAIT_CNT_W      = 3;
  localparam int BYTE_OFS_W      = 2;
  localparam int BUS_W           = 32;

  // The responder only ever reads, so every byte lane stays write-disabled.
  localparam logic [3:0] WEB_READ_ONLY = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } im_state_e;

  // True when the byte address has any bit set above the SRAM word range.
  function automatic logic addr_out_of_range(input logic [BUS_W-1:0] byte_addr,
                                             input int addr_w);
    return (byte_addr >> (addr_w + BYTE_OFS_W)) != '0;
  endfunction

endpackage

// File: rtl/im_responder.sv
// Instruction-memory responder: turns I-cache word requests into timed SRAM
// reads and holds each response until the requester consumes it.
module im_responder
  import im_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IM_enable,
  input  logic [31:0]       IM_address,
  input  logic              IM_hold,
  output logic              ready,
  output logic [31:0]       IM_data,
  output logic              IM_err,
  output logic              CS,
  output logic              OE,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  input  logic [31:0]       DO
);

  localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES);

  im_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  oor_q, oor_d;
  logic [31:0]           data_q, data_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic                  cs_q, cs_d;
  logic                  oe_q, oe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (IM_enable) begin
          state_d = ACCESS;
          addr_d  = IM_address[ADDR_W+1:BYTE_OFS_W];
          oor_d   = addr_out_of_range(IM_address, ADDR_W);
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // A withdrawn request abandons the read without touching the data register.
        if (!IM_enable) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          data_d  = oor_q ? '0 : DO;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (!IM_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ready_d = (state_d == RESP);
    err_d   = (state_d == RESP) && oor_d;
    oe_d    = (state_d == ACCESS);
    cs_d    = (state_d == ACCESS) && !oor_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      oe_q    <= oe_d;
    end
  end

  assign ready   = ready_q;
  assign IM_data = data_q;
  assign IM_err  = err_q;
  assign CS      = cs_q;
  assign OE      = oe_q;
  assign WEB     = WEB_READ_ONLY;
  assign A       = addr_q;

endmodule

// File: tb/tb_im_responder.sv
// Self-checking bench for im_responder: directed scenarios plus a randomized
// run compared every cycle against a transaction-level model.
module tb_im_responder;

  localparam int W  = 2;
  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          IM_enable;
  logic [31:0]   IM_address;
  logic          IM_hold;
  logic          ready;
  logic [31:0]   IM_data;
  logic          IM_err;
  logic          CS;
  logic          OE;
  logic [3:0]    WEB;
  logic [AW-1:0] A;
  logic [31:0]   DO;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  im_responder #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .IM_enable  (IM_enable),
    .IM_address (IM_address),
    .IM_hold    (IM_hold),
    .ready      (ready),
    .IM_data    (IM_data),
    .IM_err     (IM_err),
    .CS         (CS),
    .OE         (OE),
    .WEB        (WEB),
    .A          (A),
    .DO         (DO)
  );

  function automatic logic [31:0] sram_word(input logic [AW-1:0] a);
    if (a == 14'd4) return 32'hDEADBEEF;
    return 32'(a) * 32'h9E3779B1 + 32'h01375A2C;
  endfunction

  // SRAM: registered read; DO carries junk whenever no read was issued.
  always @(posedge clk) begin
    if (CS && OE) DO <= sram_word(A);
    else          DO <= $urandom;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request in flight spends W+1 cycles reading,
  // then a response is pending until the requester consumes it.
  bit            m_inflight, m_resp, m_oor;
  int            m_n;
  logic [AW-1:0] m_a;
  logic [31:0]   m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_inflight <= 1'b0;
      m_resp     <= 1'b0;
      m_oor      <= 1'b0;
      m_n        <= 0;
      m_a        <= '0;
      m_data     <= '0;
    end else if (m_resp) begin
      if (!IM_hold) begin
        m_resp     <= 1'b0;
        m_inflight <= 1'b0;
      end
    end else if (m_inflight) begin
      if (!IM_enable) m_inflight <= 1'b0;
      else if (m_n == W) begin
        m_resp <= 1'b1;
        m_data <= m_oor ? 32'h0 : sram_word(m_a);
      end else m_n <= m_n + 1;
    end else if (IM_enable) begin
      m_inflight <= 1'b1;
      m_n        <= 0;
      m_a        <= AW'((IM_address / 4) % (1 << AW));
      m_oor      <= (IM_address >= (32'd1 << (AW + 2)));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, m_resp);
      check("oe", OE, m_inflight && !m_resp);
      check("cs", CS, m_inflight && !m_resp && !m_oor);
      check("a", A, m_a);
      check("err", IM_err, m_resp && m_oor);
      check("web", WEB, 32'hF);
      if (m_resp) check("data", IM_data, m_data);
      if (m_resp && !IM_hold)
        $display("txn a=%h data=%h err=%0d", A, IM_data, IM_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) check("ready_timeout", ready, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] ad;
    ad = $urandom & 32'h0000_FFFF;
    if ($urandom_range(0, 7) == 0) ad[31:16] = 16'($urandom_range(1, 65535));
    return ad;
  endfunction

  initial begin
    int n;
    bit seen;
    logic [31:0] d0;

    rst = 1'b0;
    IM_enable = 1'b0;
    IM_hold = 1'b0;
    IM_address = '0;
    DO = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 0);
    check("rst_err", IM_err, 0);
    check("rst_data", IM_data, 0);
    check("rst_cs", CS, 0);
    check("rst_oe", OE, 0);
    check("rst_a", A, 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Basic read of word 4, latency W+2.
    IM_enable = 1'b1;
    IM_address = 32'h10;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("t1_a", A, 4);
      check("t1_cs", CS, 1);
      check("t1_rdy_low", ready, 0);
    end
    tick();
    check("t1_ready", ready, 1);
    check("t1_data", IM_data, 32'hDEADBEEF);
    check("t1_err", IM_err, 0);
    IM_enable = 1'b0;
    tick();
    check("t1_done", ready, 0);
    $display("scenario basic read done");

    // Hold for three cycles, enable dropped during the response.
    IM_enable = 1'b1;
    IM_address = 32'h10;
    wait_ready(n);
    check("t2_latency", n, 4);
    d0 = IM_data;
    IM_hold = 1'b1;
    IM_enable = 1'b0;
    tick(); check("t2_hold1", ready, 1); check("t2_data1", IM_data, d0);
    tick(); check("t2_hold2", ready, 1); check("t2_data2", IM_data, d0);
    tick(); check("t2_hold3", ready, 1); check("t2_data3", IM_data, d0);
    IM_hold = 1'b0;
    tick(); check("t2_idle", ready, 0);
    $display("scenario hold done");

    // Out-of-range request.
    IM_enable = 1'b1;
    IM_address = 32'h0001_0000;
    seen = 1'b0;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      seen |= CS;
      n++;
    end
    check("t4_no_cs", seen, 0);
    check("t4_ready", ready, 1);
    check("t4_err", IM_err, 1);
    check("t4_data", IM_data, 0);
    IM_enable = 1'b0;
    tick();
    $display("scenario out-of-range done");

    // Abort in the second access cycle.
    IM_enable = 1'b1;
    IM_address = 32'h30;
    tick(); check("t5_oe1", OE, 1);
    tick(); IM_enable = 1'b0;
    tick(); check("t5_oe_off", OE, 0); check("t5_no_ready", ready, 0);
    seen = 1'b0;
    repeat (4) begin tick(); seen |= ready; end
    check("t5_never_ready", seen, 0);
    $display("scenario abort done");

    // Four-beat line fill, address advanced on each consumption.
    IM_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      IM_address = 32'h20 + 32'(4 * i);
      tick();
      wait_ready(n);
      check("t3_a", A, 8 + i);
      check("t3_data", IM_data, sram_word(AW'(8 + i)));
    end
    IM_enable = 1'b0;
    tick();
    $display("scenario line fill done");

    // Asynchronous reset mid-access.
    IM_enable = 1'b1;
    IM_address = 32'h10;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("t6_cs", CS, 0);
    check("t6_oe", OE, 0);
    check("t6_a", A, 0);
    check("t6_ready", ready, 0);
    check("t6_err", IM_err, 0);
    check("t6_data", IM_data, 0);
    IM_enable = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    $display("scenario async reset done");

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      if (!IM_enable) begin
        if ($urandom_range(0, 1) == 1) begin
          IM_enable = 1'b1;
          IM_address = rand_addr();
        end
        IM_hold = ($urandom_range(0, 3) == 0);
      end else if (ready) begin
        IM_hold = ($urandom_range(0, 2) == 0);
        if (!IM_hold) begin
          if ($urandom_range(0, 1) == 1) IM_enable = 1'b0;
          else IM_address = rand_addr();
        end else if ($urandom_range(0, 3) == 0) IM_enable = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        IM_enable = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
